seq_average_pool: RTL and testbench

//   Multi-channel temporal mean pooling over a GRU hidden-state sequence of runtime length t.

---
 rtl/seq_average_pool.sv | 147 ++++++++++++++
 tb/tb_seq_average_pool.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_average_pool.sv
// Multi-channel temporal mean pooling: accumulate t samples per channel, then divide by t.
// Optional build macro AVG_ROUND_EN selects round-half-away-from-zero instead of truncation.
module seq_average_pool #(
  parameter int unsigned DW = 16,
  parameter int unsigned CH = 4,
  parameter int unsigned TW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [TW-1:0]      t,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CH*DW-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH*DW-1:0]   out_data,
  output logic               busy,
  output logic               done,
  output logic               err_zero_len
);

  localparam int unsigned AW = DW + TW;
  localparam int unsigned CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned IW = $clog2(AW + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DIV, S_OUT} state_t;

  state_t state, state_nx;

  logic [TW-1:0]        t_lat;
  logic [TW-1:0]        count;
  logic signed [AW-1:0] acc [CH];
  logic [CW-1:0]        ch_idx;
  logic [IW-1:0]        it_cnt;
  logic [AW-1:0]        quo;
  logic [TW-1:0]        rem;
  logic                 neg;

  logic                 start_ok;
  logic                 take;
  logic                 last_smp;
  logic                 div_done;

  logic [AW-1:0]        acc_sel;
  logic [AW-1:0]        mag;
  logic [AW-1:0]        dividend;
  logic [TW:0]          rem_sh;
  logic [TW:0]          sub;
  logic                 ge;
  logic [TW-1:0]        rem_nx;
  logic [AW-1:0]        quo_nx;
  logic [DW-1:0]        qd;
  logic [DW-1:0]        res;

  assign start_ok = (state == S_IDLE) && start && (t != '0);
  assign take     = (state == S_ACC) && in_valid;
  assign last_smp = take && (count == t_lat - TW'(1));
  assign div_done = (state == S_DIV) && (it_cnt == IW'(AW)) && (ch_idx == CW'(CH - 1));

  // Status decodes straight off the state register; done/err are same-cycle pulses.
  assign in_ready     = (state == S_ACC);
  assign busy         = (state != S_IDLE);
  assign out_valid    = (state == S_OUT);
  assign done         = (state == S_OUT) && out_ready;
  assign err_zero_len = (state == S_IDLE) && start && (t == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_ok)  state_nx = S_ACC;
      S_ACC:   if (last_smp)  state_nx = S_DIV;
      S_DIV:   if (div_done)  state_nx = S_OUT;
      S_OUT:   if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Restoring divider step on |acc| / t, one quotient bit per cycle.
  always_comb begin
    acc_sel = acc[ch_idx];
    mag     = acc_sel[AW-1] ? (AW'(0) - acc_sel) : acc_sel;
`ifdef AVG_ROUND_EN
    dividend = mag + AW'(t_lat >> 1);
`else
    dividend = mag;
`endif
    rem_sh = {rem, quo[AW-1]};
    ge     = (rem_sh >= {1'b0, t_lat});
    sub    = rem_sh - {1'b0, t_lat};
    rem_nx = ge ? TW'(sub) : TW'(rem_sh);
    quo_nx = {quo[AW-2:0], ge};
    qd     = quo_nx[DW-1:0];
    res    = neg ? (DW'(0) - qd) : qd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_lat    <= '0;
      count    <= '0;
      for (int unsigned k = 0; k < CH; k++) acc[k] <= '0;
      ch_idx   <= '0;
      it_cnt   <= '0;
      quo      <= '0;
      rem      <= '0;
      neg      <= 1'b0;
      out_data <= '0;
    end else begin
      if (start_ok) begin
        t_lat  <= t;
        count  <= '0;
        for (int unsigned k = 0; k < CH; k++) acc[k] <= '0;
        ch_idx <= '0;
        it_cnt <= '0;
      end
      if (take) begin
        count <= count + TW'(1);
        for (int unsigned k = 0; k < CH; k++)
          acc[k] <= acc[k] + {{TW{in_data[k*DW + DW - 1]}}, in_data[k*DW +: DW]};
      end
      if (state == S_DIV) begin
        if (it_cnt == '0) begin
          quo    <= dividend;
          rem    <= '0;
          neg    <= acc_sel[AW-1];
          it_cnt <= IW'(1);
        end else begin
          quo <= quo_nx;
          rem <= rem_nx;
          if (it_cnt == IW'(AW)) begin
            out_data[ch_idx*DW +: DW] <= res;
            it_cnt <= '0;
            ch_idx <= ch_idx + CW'(1);
          end else begin
            it_cnt <= it_cnt + IW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_average_pool.sv
// Self-checking bench for seq_average_pool against an arithmetic mean model.
module tb_seq_average_pool;

  localparam int DW   = 16;
  localparam int CH   = 4;
  localparam int TW   = 8;
  localparam int AW   = DW + TW;
  localparam int DIVC = CH * (AW + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [TW-1:0]    t = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [CH*DW-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CH*DW-1:0] out_data;
  logic             busy;
  logic             done;
  logic             err_zero_len;

  seq_average_pool #(.DW(DW), .CH(CH), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .t(t),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .err_zero_len(err_zero_len)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int smp [0:255][0:CH-1];
  int exp_mean [0:CH-1];

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_mean(input int s, input int tt);
    int m;
    m = (s < 0) ? -s : s;
`ifdef AVG_ROUND_EN
    m = (m + tt / 2) / tt;
`else
    m = m / tt;
`endif
    return (s < 0) ? -m : m;
  endfunction

  function automatic int och(input int k);
    logic [DW-1:0] v;
    v = out_data[k*DW +: DW];
    return int'($signed(v));
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_seq(input int tt);
    start = 1'b1;
    t = TW'(tt);
    @(negedge clk);
    start = 1'b0;
    t = TW'($urandom);
  endtask

  task automatic feed(input int n, input bit gaps, output int last_cyc);
    last_cyc = cyc;
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        in_valid = 1'b0;
        in_data = {$urandom, $urandom};
        @(negedge clk);
      end
      in_valid = 1'b1;
      for (int k = 0; k < CH; k++) in_data[k*DW +: DW] = DW'(smp[i][k]);
      last_cyc = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int tt, input int last_cyc);
    int n;
    int s;
    n = 0;
    while (!out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, cyc - last_cyc, 1 + DIVC);
    for (int k = 0; k < CH; k++) begin
      s = 0;
      for (int i = 0; i < tt; i++) s += smp[i][k];
      exp_mean[k] = ref_mean(s, tt);
      check($sformatf("%s_ch%0d", tag, k), och(k), exp_mean[k]);
    end
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    #1;
    check({tag, "_done"}, done, 1);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check({tag, "_done_low"}, done, 0);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_kept"}, och(CH - 1), exp_mean[CH - 1]);
  endtask

  task automatic run_full(input string tag, input int tt, input bit gaps);
    int lc;
    start_seq(tt);
    feed(tt, gaps, lc);
    wait_out(tag, tt, lc);
    accept(tag);
  endtask

  task automatic fill_const(input int tt, input int v);
    for (int i = 0; i < tt; i++)
      for (int k = 0; k < CH; k++) smp[i][k] = v;
  endtask

  task automatic fill_rand(input int tt);
    for (int i = 0; i < tt; i++)
      for (int k = 0; k < CH; k++) smp[i][k] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  initial begin
    int lc;
    bit flag;

    // Reset state
    do_reset();
    #1;
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_err", err_zero_len, 0);

    // Directed mixed-sign sequence, t=4
    smp[0][0] = 10;   smp[1][0] = 20;   smp[2][0] = 30;   smp[3][0] = 40;
    smp[0][1] = -100; smp[1][1] = -100; smp[2][1] = -100; smp[3][1] = -101;
    smp[0][2] = 1;    smp[1][2] = 2;    smp[2][2] = 0;    smp[3][2] = 0;
    smp[0][3] = -1;   smp[1][3] = -1;   smp[2][3] = 0;    smp[3][3] = 0;
    start_seq(4);
    #1;
    check("t1_busy", busy, 1);
    check("t1_in_ready", in_ready, 1);
    feed(4, 1'b0, lc);
    #1;
    check("t1_in_ready_div", in_ready, 0);
    wait_out("t1", 4, lc);
    accept("t1");

    // Extremes
    fill_const(1, -32768);
    run_full("t2a", 1, 1'b0);
    fill_const(255, 32767);
    run_full("t2b", 255, 1'b0);
    fill_const(255, -32768);
    run_full("t2c", 255, 1'b0);

    // Zero length start is rejected
    start = 1'b1;
    t = '0;
    #1;
    check("t3_err_pulse", err_zero_len, 1);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("t3_err_low", err_zero_len, 0);
    flag = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      flag = flag | busy | out_valid;
    end
    check("t3_stay_idle", flag, 0);

    // Gapped input, back-pressure, ignored start
    smp[0][0] = 3; smp[1][0] = 6; smp[2][0] = 9;
    for (int k = 1; k < CH; k++) begin
      smp[0][k] = 3; smp[1][k] = 6; smp[2][k] = 9;
    end
    start_seq(3);
    feed(3, 1'b1, lc);
    wait_out("t4", 3, lc);
    flag = 1'b0;
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      t = TW'(7);
      @(negedge clk);
      for (int k = 0; k < CH; k++) if (och(k) != exp_mean[k]) flag = 1'b1;
      if (!out_valid || done) flag = 1'b1;
    end
    start = 1'b0;
    check("t4_hold_stable", flag, 0);
    check("t4_ch0_val", och(0), 6);
    accept("t4");

    // Reset mid-accumulation leaves no residue
    fill_rand(5);
    start_seq(5);
    feed(2, 1'b0, lc);
    do_reset();
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_data", out_data, 0);
    fill_const(1, 100);
    for (int k = 0; k < CH; k++) smp[1][k] = 200;
    run_full("t5", 2, 1'b0);
    check("t5_val", och(2), 150);

    // Reset mid-division
    fill_rand(6);
    start_seq(6);
    feed(6, 1'b0, lc);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6_idle", busy, 0);
    flag = 1'b0;
    for (int i = 0; i < DIVC + 10; i++) begin
      @(negedge clk);
      flag = flag | out_valid;
    end
    check("t6_no_valid", flag, 0);
    fill_rand(7);
    run_full("t6", 7, 1'b0);

    // Randomized runs
    for (int r = 0; r < 4; r++) begin
      int tt;
      tt = int'($urandom_range(1, 40));
      fill_rand(tt);
      run_full($sformatf("rnd%0d", r), tt, r[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
